csa_stream_accumulator: RTL and testbench

//   Parametrised multi-operand accumulator built on 3:2 carry-save compression.

---
 rtl/csa_stream_accumulator_if.sv | 29 ++
 rtl/csa_stream_accumulator.sv | 106 ++++++++++
 tb/tb_csa_stream_accumulator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/csa_stream_accumulator_if.sv
// Stream interface for the carry-save accumulator: the operand input channel
// and the resolved-result output channel, each with its own valid/ready pair.
interface csa_stream_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  // Producer/consumer side, as seen from outside the accumulator
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Multi-operand stream accumulator. The running total is kept in redundant
// sum/carry form so each accept is a single 3:2 compression with no carry
// chain. After the last operand the pair is resolved by repeated half-adder
// passes until the carry word is zero, then the result is offered on the
// output handshake.
module csa_stream_accumulator #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  csa_stream_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACC,
    ST_RESOLVE,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [ACC_W-1:0] r_s;
  logic [ACC_W-1:0] r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] w_sNext;
  logic [ACC_W-1:0] w_cNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_ovfNext;
  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] w_maj;
  logic             w_accept;

  assign w_x      = ACC_W'(bus.in_data);
  assign w_maj    = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
  assign w_accept = (r_state == ST_ACC) && bus.in_valid;

  // State register; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_s     <= '0;
      r_c     <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_s     <= w_sNext;
      r_c     <= w_cNext;
      r_cnt   <= w_cntNext;
      r_ovf   <= w_ovfNext;
    end
  end

  // Next-state logic: compress on accept, resolve until carry is zero, clear on result hand-off
  always_comb begin
    w_stateNext = r_state;
    w_sNext     = r_s;
    w_cNext     = r_c;
    w_cntNext   = r_cnt;
    w_ovfNext   = r_ovf;
    case (r_state)
      ST_ACC: begin
        if (w_accept) begin
          w_sNext   = r_s ^ r_c ^ w_x;
          w_cNext   = w_maj << 1;
          w_ovfNext = r_ovf | w_maj[ACC_W-1];
          w_cntNext = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
          if (bus.in_last) begin
            w_stateNext = ST_RESOLVE;
          end
        end
      end
      ST_RESOLVE: begin
        if (r_c == '0) begin
          w_stateNext = ST_DONE;
        end else begin
          w_sNext   = r_s ^ r_c;
          w_cNext   = (r_s & r_c) << 1;
          w_ovfNext = r_ovf | (r_s[ACC_W-1] & r_c[ACC_W-1]);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_stateNext = ST_ACC;
          w_sNext     = '0;
          w_cNext     = '0;
          w_cntNext   = '0;
          w_ovfNext   = 1'b0;
        end
      end
      default: begin
        w_stateNext = ST_ACC;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == ST_ACC);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_sum   = (r_state == ST_DONE) ? r_s   : '0;
  assign bus.out_count = (r_state == ST_DONE) ? r_cnt : '0;
  assign bus.out_ovf   = (r_state == ST_DONE) ? r_ovf : 1'b0;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed and random streams for the carry-save accumulator. Expected results
// come from an integer model of the running total and are queued when the last
// operand is accepted, then popped when the result appears.
module tb_csa_stream_accumulator;

  localparam int WIDTH = 8;
  localparam int ACC_W = 12;
  localparam int CNT_W = 8;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  csa_stream_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  csa_stream_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  exp_t sbQ[$];
  int   checks;
  int   errors;
  int   cycle;
  int   lastAcceptCycle;
  int   mTotal;
  int   mCount;

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand (optionally after an idle cycle) and update the model
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last, input bit idle);
    int guard;
    if (idle) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom_range(0, 1));
      step();
      bus.in_last  = 1'b0;
    end
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      step();
      guard++;
    end
    checkOutput("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    mTotal += int'(data);
    mCount++;
    if (last) begin
      exp_t e;
      e.sum = ACC_W'(mTotal % (1 << ACC_W));
      e.cnt = (mCount > 255) ? CNT_W'(255) : CNT_W'(mCount);
      e.ovf = (mTotal >= (1 << ACC_W));
      sbQ.push_back(e);
      lastAcceptCycle = cycle;
      mTotal = 0;
      mCount = 0;
    end
  endtask

  // Wait for a result, compare it with the queued expectation, hold it, then accept it
  task automatic collectResult(input int holdCycles, input bit randomReady, input string tag,
                               output int resolveCycles);
    int   guard;
    bit   taken;
    exp_t e;
    bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin
      step();
      guard++;
    end
    resolveCycles = cycle - lastAcceptCycle;
    checkOutput({tag, "_valid"}, bus.out_valid, 1);
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sbQ.pop_front();
    if (!bus.out_valid) return;
    checkOutput({tag, "_sum"},      bus.out_sum,   e.sum);
    checkOutput({tag, "_count"},    bus.out_count, e.cnt);
    checkOutput({tag, "_ovf"},      bus.out_ovf,   e.ovf);
    checkOutput({tag, "_in_ready"}, bus.in_ready,  0);
    for (int h = 0; h < holdCycles; h++) begin
      step();
      checkOutput({tag, "_hold_valid"},    bus.out_valid, 1);
      checkOutput({tag, "_hold_sum"},      bus.out_sum,   e.sum);
      checkOutput({tag, "_hold_count"},    bus.out_count, e.cnt);
      checkOutput({tag, "_hold_in_ready"}, bus.in_ready,  0);
    end
    taken = 1'b0;
    guard = 0;
    while (!taken && guard < 64) begin
      bus.out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      taken = bus.out_ready;
      step();
      guard++;
    end
    bus.out_ready = 1'b0;
    checkOutput({tag, "_post_valid"},    bus.out_valid, 0);
    checkOutput({tag, "_post_in_ready"}, bus.in_ready,  1);
  endtask

  // Directed tests followed by random streams
  initial begin
    int   rc;
    int   len;
    exp_t discard;
    checks = 0;
    errors = 0;
    cycle = 0;
    lastAcceptCycle = 0;
    mTotal = 0;
    mCount = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    checkOutput("rst_in_ready",  bus.in_ready,  1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_sum",   bus.out_sum,   0);
    checkOutput("rst_out_count", bus.out_count, 0);
    checkOutput("rst_out_ovf",   bus.out_ovf,   0);
    rst = 1'b0;
    step();

    // Single operand
    applyStimulus(8'h5A, 1'b1, 1'b0);
    collectResult(0, 1'b0, "t1", rc);
    checkOutput("t1_resolve_cycles", rc, 1);

    // in_last without in_valid must be ignored
    bus.in_last = 1'b1;
    step();
    bus.in_last = 1'b0;
    step();
    checkOutput("t2_stray_last_ready", bus.in_ready,  1);
    checkOutput("t2_stray_last_valid", bus.out_valid, 0);

    // Back-to-back stream 3,5,7
    checkOutput("t2_ready_op0", bus.in_ready, 1);
    applyStimulus(8'd3, 1'b0, 1'b0);
    checkOutput("t2_ready_op1", bus.in_ready, 1);
    applyStimulus(8'd5, 1'b0, 1'b0);
    checkOutput("t2_ready_op2", bus.in_ready, 1);
    applyStimulus(8'd7, 1'b1, 1'b0);
    collectResult(0, 1'b0, "t2", rc);

    // 17 x 0xFF overflows a 12-bit total
    for (int i = 0; i < 17; i++) begin
      applyStimulus(8'hFF, (i == 16), 1'b0);
    end
    collectResult(0, 1'b0, "t3", rc);
    checkOutput("t3_resolve_bound", (rc <= ACC_W + 1), 1);

    // Result held while the consumer stalls
    applyStimulus(8'd10, 1'b0, 1'b0);
    applyStimulus(8'd20, 1'b1, 1'b0);
    collectResult(5, 1'b0, "t4", rc);

    // Reset during resolve discards the stream
    applyStimulus(8'hFF, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkOutput("t5_in_resolve", bus.in_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    discard = sbQ.pop_back();
    checkOutput("t5_rst_out_valid", bus.out_valid, 0);
    checkOutput("t5_rst_in_ready",  bus.in_ready,  1);
    checkOutput("t5_rst_out_sum",   bus.out_sum,   0);
    applyStimulus(8'd1, 1'b0, 1'b0);
    applyStimulus(8'd1, 1'b1, 1'b0);
    collectResult(0, 1'b0, "t5", rc);

    // Random streams with idle gaps and random consumer back-pressure
    for (int s = 0; s < 256; s++) begin
      len = $urandom_range(1, 300);
      for (int i = 0; i < len; i++) begin
        applyStimulus(8'($urandom_range(0, 255)), (i == len - 1), ($urandom_range(0, 3) == 0));
      end
      collectResult(0, 1'b1, "rand", rc);
      checkOutput("rand_resolve_bound", (rc <= ACC_W + 1), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
